// File: rtl/shift_arbiter.sv
// Two-requester arbiter in front of one shared barrel shifter, with a one-entry result register.
// Define SHIFT_ARBITER_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module shift_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AMT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [WIDTH-1:0] req0_data_i,
  input  logic [AMT_W-1:0] req0_amount_i,
  input  logic             req0_arith_i,
  input  logic             req0_left_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [WIDTH-1:0] req1_data_i,
  input  logic [AMT_W-1:0] req1_amount_i,
  input  logic             req1_arith_i,
  input  logic             req1_left_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_id_o
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state;
  logic             accept;
  logic             grant0;
  logic             grant1;
  logic             grant_any;
  logic [WIDTH-1:0] sel_data;
  logic [AMT_W-1:0] sel_amount;
  logic             sel_arith;
  logic             sel_left;
  logic [WIDTH-1:0] shifted;

  // A new result fits when the register is empty or is being drained this cycle.
  assign accept = rst_ni & ((state == EMPTY) | out_ready_i);

`ifdef SHIFT_ARBITER_RR_EN
  logic ptr;
  assign grant0 = accept & req0_valid_i & (~req1_valid_i | ~ptr);
  assign grant1 = accept & req1_valid_i & (~req0_valid_i | ptr);
`else
  assign grant0 = accept & req0_valid_i;
  assign grant1 = accept & req1_valid_i & ~req0_valid_i;
`endif

  assign grant_any    = grant0 | grant1;
  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;

  // Operand mux feeding the shared shifter.
  always_comb begin
    sel_data   = req0_data_i;
    sel_amount = req0_amount_i;
    sel_arith  = req0_arith_i;
    sel_left   = req0_left_i;
    if (grant1) begin
      sel_data   = req1_data_i;
      sel_amount = req1_amount_i;
      sel_arith  = req1_arith_i;
      sel_left   = req1_left_i;
    end
  end

  always_comb begin
    shifted = '0;
    if (sel_left)       shifted = sel_data << sel_amount;
    else if (sel_arith) shifted = WIDTH'($signed(sel_data) >>> sel_amount);
    else                shifted = sel_data >> sel_amount;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= EMPTY;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_id_o    <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (grant_any) begin
            state       <= FULL;
            out_valid_o <= 1'b1;
            out_data_o  <= shifted;
            out_id_o    <= grant1;
          end
        end
        FULL: begin
          if (grant_any) begin
            out_data_o <= shifted;
            out_id_o   <= grant1;
          end else if (out_ready_i) begin
            state       <= EMPTY;
            out_valid_o <= 1'b0;
          end
        end
        default: begin
          state       <= EMPTY;
          out_valid_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef SHIFT_ARBITER_RR_EN
  // Pointer moves to the requester that did not just win.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)        ptr <= 1'b0;
    else if (grant_any) ptr <= grant0;
  end
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed scenarios plus a randomized scoreboard run.
module tb_shift_arbiter;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned AMT_W = 5;
  localparam int NREQ = 50;
`ifdef SHIFT_ARBITER_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_ni;
  logic req0_valid_i, req0_ready_o, req0_arith_i, req0_left_i;
  logic req1_valid_i, req1_ready_o, req1_arith_i, req1_left_i;
  logic [WIDTH-1:0] req0_data_i, req1_data_i, out_data_o;
  logic [AMT_W-1:0] req0_amount_i, req1_amount_i;
  logic out_valid_o, out_ready_i, out_id_o;

  int checks = 0;
  int errors = 0;

  shift_arbiter #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_data_i(req0_data_i),
    .req0_amount_i(req0_amount_i), .req0_arith_i(req0_arith_i), .req0_left_i(req0_left_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_data_i(req1_data_i),
    .req1_amount_i(req1_amount_i), .req1_arith_i(req1_arith_i), .req1_left_i(req1_left_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_id_o(out_id_o)
  );

  always #5 clk = ~clk;

  // Bit-by-bit reference shifter.
  function automatic logic [WIDTH-1:0] model_shift(input logic [WIDTH-1:0] d, input int amt,
                                                   input bit arith, input bit left);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (left) r[i] = (i >= amt) ? d[i-amt] : 1'b0;
      else      r[i] = (i + amt < int'(WIDTH)) ? d[i+amt] : (arith ? d[WIDTH-1] : 1'b0);
    end
    return r;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid_i = 0; req0_data_i = '0; req0_amount_i = '0; req0_arith_i = 0; req0_left_i = 0;
    req1_valid_i = 0; req1_data_i = '0; req1_amount_i = '0; req1_arith_i = 0; req1_left_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    out_ready_i = 1;
    rst_ni = 0;
    cycle();
    rst_ni = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 0;
    req0_valid_i = 1; req1_valid_i = 1; out_ready_i = 1;
    cycle(); cycle();
    #2;
    checks++;
    if (req0_ready_o !== 1'b0 || req1_ready_o !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b%b want 00", req0_ready_o, req1_ready_o);
    end
    checks++;
    if (out_valid_o !== 1'b0 || out_data_o !== '0 || out_id_o !== 1'b0) begin
      errors++; $display("FAIL reset_out: got v=%b d=%h id=%b want 0/0/0", out_valid_o, out_data_o, out_id_o);
    end
    idle_inputs();
    cycle();
    rst_ni = 1;
  endtask

  task automatic test_basic();
    do_reset();
    req0_valid_i = 1; req0_data_i = 32'h8000_0001; req0_amount_i = 5'd4;
    req0_left_i = 0; req0_arith_i = 1;
    #2;
    checks++;
    if (req0_ready_o !== 1'b1 || req1_ready_o !== 1'b0) begin
      errors++; $display("FAIL basic_ready: got %b%b want 10", req0_ready_o, req1_ready_o);
    end
    cycle();
    idle_inputs();
    checks++;
    if (out_valid_o !== 1'b1 || out_data_o !== 32'hF800_0000 || out_id_o !== 1'b0) begin
      errors++; $display("FAIL basic_out: got v=%b d=%h id=%b want 1/f8000000/0", out_valid_o, out_data_o, out_id_o);
    end
    cycle();
    checks++;
    if (out_valid_o !== 1'b0) begin
      errors++; $display("FAIL basic_drain: got v=%b want 0", out_valid_o);
    end
  endtask

  task automatic test_hold();
    do_reset();
    out_ready_i = 0;
    req1_valid_i = 1; req1_data_i = 32'h0000_00FF; req1_amount_i = 5'd8; req1_left_i = 1;
    #2;
    checks++;
    if (req1_ready_o !== 1'b1 || req0_ready_o !== 1'b0) begin
      errors++; $display("FAIL hold_grant: got %b%b want 01", req0_ready_o, req1_ready_o);
    end
    cycle();
    req0_valid_i = 1; req0_data_i = 32'h1234_5678;
    for (int k = 0; k < 3; k++) begin
      #2;
      checks++;
      if (out_valid_o !== 1'b1 || out_data_o !== 32'h0000_FF00 || out_id_o !== 1'b1) begin
        errors++; $display("FAIL hold_out[%0d]: got v=%b d=%h id=%b want 1/0000ff00/1", k, out_valid_o, out_data_o, out_id_o);
      end
      checks++;
      if (req0_ready_o !== 1'b0 || req1_ready_o !== 1'b0) begin
        errors++; $display("FAIL hold_ready[%0d]: got %b%b want 00", k, req0_ready_o, req1_ready_o);
      end
      cycle();
    end
    idle_inputs();
    out_ready_i = 1;
    cycle();
  endtask

  task automatic test_back_to_back();
    bit ptr, exp_id;
    logic [WIDTH-1:0] exp_d;
    do_reset();
    ptr = 0;
    out_ready_i = 1;
    req0_valid_i = 1; req0_data_i = 32'h0000_1111; req0_amount_i = 5'd1; req0_left_i = 1;
    req1_valid_i = 1; req1_data_i = 32'h0000_2222; req1_amount_i = 5'd1; req1_left_i = 0;
    for (int k = 0; k < 4; k++) begin
      exp_id = RR_EN && ptr;
      exp_d  = exp_id ? 32'h0000_1111 : 32'h0000_2222;
      #2;
      checks++;
      if (req0_ready_o !== !exp_id || req1_ready_o !== exp_id) begin
        errors++; $display("FAIL b2b_ready[%0d]: got %b%b want %b%b", k, req0_ready_o, req1_ready_o, !exp_id, exp_id);
      end
      cycle();
      checks++;
      if (out_valid_o !== 1'b1 || out_id_o !== exp_id || out_data_o !== exp_d) begin
        errors++; $display("FAIL b2b_out[%0d]: got v=%b id=%b d=%h want 1/%b/%h", k, out_valid_o, out_id_o, out_data_o, exp_id, exp_d);
      end
      ptr = !exp_id;
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_amount();
    logic [AMT_W-1:0] amt_t [5] = '{5'd0, 5'd0, 5'd0, 5'd31, 5'd31};
    bit arith_t [5] = '{0, 0, 1, 0, 1};
    bit left_t  [5] = '{1, 0, 0, 0, 0};
    logic [WIDTH-1:0] exp_t [5] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0001, 32'hFFFF_FFFF};
    do_reset();
    out_ready_i = 1;
    for (int k = 0; k < 5; k++) begin
      req0_valid_i = 1; req0_data_i = 32'hDEAD_BEEF;
      req0_amount_i = amt_t[k]; req0_arith_i = arith_t[k]; req0_left_i = left_t[k];
      cycle();
      idle_inputs();
      checks++;
      if (out_valid_o !== 1'b1 || out_data_o !== exp_t[k]) begin
        errors++; $display("FAIL amount[%0d]: got v=%b d=%h want 1/%h", k, out_valid_o, out_data_o, exp_t[k]);
      end
      cycle();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready_i = 0;
    req0_valid_i = 1; req0_data_i = 32'hCAFE_0000; req0_amount_i = 5'd3;
    cycle();
    checks++;
    if (out_valid_o !== 1'b1) begin
      errors++; $display("FAIL midrst_full: got v=%b want 1", out_valid_o);
    end
    rst_ni = 0;
    req1_valid_i = 1; out_ready_i = 1;
    #2;
    checks++;
    if (req0_ready_o !== 1'b0 || req1_ready_o !== 1'b0) begin
      errors++; $display("FAIL midrst_ready: got %b%b want 00", req0_ready_o, req1_ready_o);
    end
    cycle();
    rst_ni = 1;
    idle_inputs();
    checks++;
    if (out_valid_o !== 1'b0 || out_data_o !== '0 || out_id_o !== 1'b0) begin
      errors++; $display("FAIL midrst_out: got v=%b d=%h id=%b want 0/0/0", out_valid_o, out_data_o, out_id_o);
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] d0 [NREQ], d1 [NREQ];
    int a0 [NREQ], a1 [NREQ];
    bit s0 [NREQ], s1 [NREQ], l0 [NREQ], l1 [NREQ];
    logic [WIDTH-1:0] exp_d [$];
    bit exp_id [$];
    int i0, i1, cyc;
    bit h0, h1, full, ptr, acc, g0, g1;
    for (int k = 0; k < NREQ; k++) begin
      d0[k] = $urandom; a0[k] = $urandom_range(0, 31); s0[k] = 1'($urandom); l0[k] = 1'($urandom);
      d1[k] = $urandom; a1[k] = $urandom_range(0, 31); s1[k] = 1'($urandom); l1[k] = 1'($urandom);
    end
    do_reset();
    i0 = 0; i1 = 0; h0 = 0; h1 = 0; full = 0; ptr = 0; cyc = 0;
    while ((i0 < NREQ || i1 < NREQ || full) && cyc < 3000) begin
      if (!h0 && i0 < NREQ && $urandom_range(0, 1) == 1) h0 = 1;
      if (!h1 && i1 < NREQ && $urandom_range(0, 1) == 1) h1 = 1;
      req0_valid_i = h0;
      req1_valid_i = h1;
      if (i0 < NREQ) begin
        req0_data_i = d0[i0]; req0_amount_i = AMT_W'(a0[i0]); req0_arith_i = s0[i0]; req0_left_i = l0[i0];
      end
      if (i1 < NREQ) begin
        req1_data_i = d1[i1]; req1_amount_i = AMT_W'(a1[i1]); req1_arith_i = s1[i1]; req1_left_i = l1[i1];
      end
      out_ready_i = 1'($urandom);
      #2;
      acc = !full || out_ready_i;
      g0 = 0; g1 = 0;
      if (acc && h0 && h1) begin
        if (RR_EN && ptr) g1 = 1; else g0 = 1;
      end else if (acc && h0) g0 = 1;
      else if (acc && h1) g1 = 1;
      checks++;
      if (req0_ready_o !== g0 || req1_ready_o !== g1) begin
        errors++; $display("FAIL rand_ready c%0d: got %b%b want %b%b", cyc, req0_ready_o, req1_ready_o, g0, g1);
      end
      checks++;
      if (out_valid_o !== full) begin
        errors++; $display("FAIL rand_valid c%0d: got %b want %b", cyc, out_valid_o, full);
      end
      if (full && out_ready_i) begin
        checks++;
        if (out_data_o !== exp_d[0] || out_id_o !== exp_id[0]) begin
          errors++; $display("FAIL rand_result c%0d: got id=%b d=%h want id=%b d=%h", cyc, out_id_o, out_data_o, exp_id[0], exp_d[0]);
        end
        void'(exp_d.pop_front());
        void'(exp_id.pop_front());
        full = 0;
      end
      if (g0) begin
        exp_d.push_back(model_shift(d0[i0], a0[i0], s0[i0], l0[i0])); exp_id.push_back(1'b0);
        i0++; h0 = 0; full = 1; ptr = 1;
      end else if (g1) begin
        exp_d.push_back(model_shift(d1[i1], a1[i1], s1[i1], l1[i1])); exp_id.push_back(1'b1);
        i1++; h1 = 0; full = 1; ptr = 0;
      end
      cycle();
      cyc++;
    end
    idle_inputs();
    checks++;
    if (cyc >= 3000 || i0 != NREQ || i1 != NREQ || exp_d.size() != 0) begin
      errors++; $display("FAIL rand_complete: got cyc=%0d n0=%0d n1=%0d left=%0d want n0=n1=%0d left=0", cyc, i0, i1, exp_d.size(), NREQ);
    end
  endtask

  initial begin
    idle_inputs();
    rst_ni = 0;
    out_ready_i = 0;
    cycle();
    test_reset();
    test_basic();
    test_hold();
    test_back_to_back();
    test_amount();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the shift datapath width in bits (power of two, >= 2).
REQ-002 SHALL have parameter AMT_W, default $clog2(WIDTH), the shift amount width.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  reset, synchronous, active-low.
REQ-005 reqN_valid_i (N=0,1)  input  1  requester N presents a shift request.
REQ-006 reqN_ready_o (N=0,1)  output  1  requester N's request is accepted this cycle.
REQ-007 reqN_data_i (N=0,1)  input  WIDTH  operand to shift.
REQ-008 reqN_amount_i (N=0,1)  input  AMT_W  shift amount.
REQ-009 reqN_arith_i (N=0,1)  input  1  1 = arithmetic right shift; ignored when left shift.
REQ-010 reqN_left_i (N=0,1)  input  1  1 = left shift, 0 = right shift.
REQ-011 out_valid_o  output  1  result register holds a valid result.
REQ-012 out_ready_i  input  1  consumer accepts the result.
REQ-013 out_data_o  output  WIDTH  shifted result.
REQ-014 out_id_o  output  1  index of the requester that produced out_data_o.

Function
REQ-015 SHALL share one combinational shifter between both requesters: left -> data << amount; right with arith=0 -> logical >>; right with arith=1 -> sign-filling >>.
REQ-016 SHALL use two states: EMPTY (result register empty) and FULL (result register holds an unconsumed result).
REQ-017 SHALL be able to accept (grant) when state is EMPTY, or when FULL and out_ready_i=1 in the same cycle.
REQ-018 SHALL grant at most one requester per cycle; reqN_ready_o SHALL be 1 only for the granted requester and only when its valid is 1.
REQ-019 SHALL load the shifted result and the granted index into out_data_o/out_id_o on the grant edge; out_valid_o SHALL be 1 the next cycle (latency 1).
REQ-020 Transitions: EMPTY->FULL on grant; FULL->EMPTY on out_ready_i=1 without a grant; FULL->FULL on out_ready_i=0, or on out_ready_i=1 with a grant (back-to-back, no bubble).
REQ-021 SHALL hold out_data_o, out_id_o and out_valid_o stable while FULL and out_ready_i=0.
REQ-022 reqN_ready_o SHALL be combinational from valids, state, out_ready_i and priority pointer; no dependency of ready on reqN_data_i.
REQ-023 With one requester valid, that requester SHALL be granted whenever acceptance is possible.
REQ-024 amount = 0 SHALL return data unchanged; amount = WIDTH-1 arithmetic right SHALL return all sign bits.

Reset
REQ-025 On rst_ni=0 at a clock edge: state EMPTY, out_valid_o=0, out_data_o=0, out_id_o=0, priority pointer = requester 0.
REQ-026 While rst_ni=0, both reqN_ready_o SHALL be 0; reset mid-transfer SHALL discard any held result.

Configuration
REQ-027 Macro SHIFT_ARBITER_RR_EN defined: round-robin; priority pointer SHALL move to the other requester after every grant; on contention the pointed-to requester SHALL win.
REQ-028 Macro SHIFT_ARBITER_RR_EN undefined: fixed priority; requester 0 SHALL always win contention; no pointer state exists.

Verification
REQ-029 After reset, req0 valid, data=0x8000_0001, amount=4, left=0, arith=1 -> req0_ready_o=1 that cycle; next cycle out_valid_o=1, out_data_o=0xF800_0000, out_id_o=0.
REQ-030 req1 valid, data=0x0000_00FF, amount=8, left=1, out_ready_i held 0 for 3 cycles -> out_data_o=0x0000_FF00, out_id_o=1, stable 3 cycles; both readys 0 while held.
REQ-031 Both valid continuously, out_ready_i=1 -> with SHIFT_ARBITER_RR_EN out_id_o sequence 0,1,0,1 with out_valid_o=1 every cycle; without it sequence 0,0,0,0.
REQ-032 data=0xDEAD_BEEF, amount=0, each of the three modes -> out_data_o=0xDEAD_BEEF each time; amount=31 logical right -> 0x0000_0001.
REQ-033 Assert rst_ni=0 for one cycle while FULL with out_ready_i=0 -> next cycle out_valid_o=0, out_data_o=0, readys 0 during reset.
REQ-034 100 random requests on both ports with random out_ready_i -> every result matches a software model and per-requester order is preserved; no request lost or duplicated.
